// File: rtl/fifo_pkg.sv
// fifo_pkg: pointer helpers shared by the read- and write-side FIFO controllers.
// Pointer convention: every controller declares localparam PTR_W = ADDR_WIDTH + 1,
// the extra MSB distinguishing full from empty.
package fifo_pkg;

    // Binary to reflected Gray; callers cast the result down to PTR_W bits.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/fifo_rd_ctrl_gray2bin.sv
// gray2bin: combinational Gray-to-binary decoder.
// Ports: gray (WIDTH in) Gray code; bin (WIDTH out) binary value.
module gray2bin #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Each binary bit is the XOR of all Gray bits at or above it.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-domain pointer, empty, almost-empty, count and underflow state.
// Ports: rclk/rrst clock and sync active-high reset; rinc read request;
//        rq2_wptr synchronised Gray write pointer; runderflow_clr clears underflow;
//        raddr RAM read address; rptr Gray read pointer; rempty, ralmost_empty,
//        rcount, runderflow registered status.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int AE_THRESH  = 1
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  rinc,
    input  logic [ADDR_WIDTH:0]   rq2_wptr,
    input  logic                  runderflow_clr,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic [ADDR_WIDTH:0]   rptr,
    output logic                  rempty,
    output logic                  ralmost_empty,
    output logic [ADDR_WIDTH:0]   rcount,
    output logic                  runderflow
);

    localparam int PTR_W = ADDR_WIDTH + 1;

    logic [PTR_W-1:0] rbin, rbin_n, rgray_n, wbin, cnt_n;
    logic             rd_ok, uf_n;

    gray2bin #(.WIDTH(PTR_W)) u_g2b (
        .gray(rq2_wptr),
        .bin (wbin)
    );

    // Flags are computed from the post-read pointer so rempty rises on the
    // edge that takes the last word.
    always_comb begin
        rd_ok   = rinc & ~rempty;
        rbin_n  = rbin + PTR_W'(rd_ok);
        rgray_n = PTR_W'(bin2gray(32'(rbin_n)));
        cnt_n   = wbin - rbin_n;
        uf_n    = (rinc & rempty) | (runderflow & ~runderflow_clr);
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin          <= '0;
            rptr          <= '0;
            rempty        <= 1'b1;
            ralmost_empty <= 1'b1;
            rcount        <= '0;
            runderflow    <= 1'b0;
        end else begin
            rbin          <= rbin_n;
            rptr          <= rgray_n;
            rempty        <= rgray_n == rq2_wptr;
            ralmost_empty <= cnt_n <= PTR_W'(AE_THRESH);
            rcount        <= cnt_n;
            runderflow    <= uf_n;
        end
    end

    assign raddr = rbin[ADDR_WIDTH-1:0];

endmodule
